// File: rtl/pe_pkg.sv
// Shared definitions for the convolution PE: FSM encoding, packing constants and arithmetic helpers.
package pe_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned LANES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(LANES_PER_WORD);

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_STORE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  // Clamp v to the largest unsigned value representable in w bits.
  function automatic logic [63:0] saturate(input logic [63:0] v, input int unsigned w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One channel MAC lane: selects the weight for the delayed tap and accumulates pix*w.
module pe_mac_lane #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned TW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [TW-1:0]         tap,
  input  logic [DATA_W-1:0]     pix,
  input  logic [K*K*DATA_W-1:0] w,
  output logic [ACC_W-1:0]      acc
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [DATA_W-1:0] w_sel;
  logic [PW-1:0]     prod;

  always_comb begin
    w_sel = w[32'(tap)*DATA_W +: DATA_W];
    prod  = PW'(pix) * PW'(w_sel);
  end

  // First tap of a window loads the product instead of adding to the stale sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? ACC_W'(0) : acc) + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/pe_conv_engine.sv
// Convolution PE: windowed multi-channel MAC, scale/saturate, 4-per-word packing into a result RAM.
module pe_conv_engine import pe_pkg::*; #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IMG_SIZE  = 16,
  parameter int unsigned K         = 4,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MEM_DEPTH = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sat_en,
  output logic                              busy,
  output logic                              done,
  output logic                              img_rd_en,
  output logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0] img_rd_addr,
  input  logic [NUM_CH*DATA_W-1:0]          img_rd_data,
  input  logic [NUM_CH*K*K*DATA_W-1:0]      filt_w,
  input  logic [$clog2(MEM_DEPTH)-1:0]      res_rd_addr,
  output logic [4*OUT_W-1:0]                res_rd_data,
  output logic [$clog2(MEM_DEPTH):0]        wr_count
);

  localparam int unsigned OD  = out_dim(IMG_SIZE, K, STRIDE);
  localparam int unsigned CW  = $clog2(IMG_SIZE + 1);
  localparam int unsigned AW  = $clog2(IMG_SIZE * IMG_SIZE);
  localparam int unsigned TW  = $clog2(K * K + 1);
  localparam int unsigned MAW = $clog2(MEM_DEPTH);
  localparam int unsigned WCW = MAW + 1;
  localparam int unsigned WW  = LANES_PER_WORD * OUT_W;

  state_t              state, state_nx;
  logic [CW-1:0]       kx, ky, ox, oy;
  logic [CW-1:0]       kx_nx, ky_nx, ox_nx, oy_nx;
  logic [AW-1:0]       addr_nx;
  logic [TW-1:0]       tap_cur, tap_d;
  logic                valid_d, first_d;
  logic                last_out;
  logic                sat_en_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WW-1:0]       pack, merged;
  logic                wr_en;
  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [ACC_W-1:0]    sum, scaled;
  logic [OUT_W-1:0]    res;
  logic [WW-1:0]       mem [MEM_DEPTH];

  // Next-state, window counters and the address for the next tap.
  always_comb begin
    state_nx = state;
    kx_nx    = kx;
    ky_nx    = ky;
    ox_nx    = ox;
    oy_nx    = oy;
    last_out = (ox == CW'(OD - 1)) && (oy == CW'(OD - 1));
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FETCH;
          kx_nx    = '0;
          ky_nx    = '0;
          ox_nx    = '0;
          oy_nx    = '0;
        end
      end
      ST_FETCH: begin
        if (kx == CW'(K - 1)) begin
          kx_nx = '0;
          if (ky == CW'(K - 1)) begin
            ky_nx    = '0;
            state_nx = ST_DRAIN;
          end else begin
            ky_nx = ky + CW'(1);
          end
        end else begin
          kx_nx = kx + CW'(1);
        end
      end
      ST_DRAIN: state_nx = ST_STORE;
      ST_STORE: begin
        if (last_out) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_FETCH;
          if (ox == CW'(OD - 1)) begin
            ox_nx = '0;
            oy_nx = oy + CW'(1);
          end else begin
            ox_nx = ox + CW'(1);
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    addr_nx = AW'((32'(oy_nx) * STRIDE + 32'(ky_nx)) * IMG_SIZE + 32'(ox_nx) * STRIDE + 32'(kx_nx));
    tap_cur = TW'(32'(ky) * K + 32'(kx));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      kx          <= '0;
      ky          <= '0;
      ox          <= '0;
      oy          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      img_rd_en   <= 1'b0;
      img_rd_addr <= '0;
    end else begin
      state     <= state_nx;
      kx        <= kx_nx;
      ky        <= ky_nx;
      ox        <= ox_nx;
      oy        <= oy_nx;
      busy      <= (state_nx == ST_FETCH) || (state_nx == ST_DRAIN) || (state_nx == ST_STORE);
      done      <= (state_nx == ST_DONE);
      img_rd_en <= (state_nx == ST_FETCH);
      if (state_nx == ST_FETCH) begin
        img_rd_addr <= addr_nx;
      end
    end
  end

  // Pixel data lags its address by one cycle, so the tap index travels with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_d   <= '0;
      valid_d <= 1'b0;
      first_d <= 1'b0;
    end else begin
      tap_d   <= tap_cur;
      valid_d <= (state == ST_FETCH);
      first_d <= (state == ST_FETCH) && (tap_cur == '0);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pe_mac_lane #(
      .DATA_W (DATA_W),
      .K      (K),
      .ACC_W  (ACC_W),
      .TW     (TW)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (valid_d),
      .clr (first_d),
      .tap (tap_d),
      .pix (img_rd_data[c*DATA_W +: DATA_W]),
      .w   (filt_w[c*K*K*DATA_W +: K*K*DATA_W]),
      .acc (acc[c])
    );
  end

  // Channel reduction, scaling and output stage merged into the pending word.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = sum + acc[c];
    end
    scaled = sum >> SHIFT;
    res    = sat_en_q ? OUT_W'(saturate(64'(scaled), OUT_W)) : OUT_W'(scaled);
    merged = pack | (WW'(res) << (32'(lane_q) * OUT_W));
    wr_en  = (state == ST_STORE) && ((lane_q == LANE_W'(LANES_PER_WORD - 1)) || last_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_en_q <= 1'b0;
      lane_q   <= '0;
      pack     <= '0;
      wr_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      sat_en_q <= sat_en;
      lane_q   <= '0;
      pack     <= '0;
      wr_count <= '0;
    end else if (state == ST_STORE) begin
      lane_q <= lane_q + LANE_W'(1);
      pack   <= wr_en ? WW'(0) : merged;
      if (wr_en) begin
        wr_count <= wr_count + WCW'(1);
      end
    end
  end

  // Result RAM is intentionally not reset; the read port returns pre-write data on collisions.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_count[MAW-1:0]] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_rd_data <= '0;
    end else begin
      res_rd_data <= mem[res_rd_addr];
    end
  end

endmodule

// File: tb/tb_pe_conv_engine.sv
// Randomised bench for pe_conv_engine against an arithmetic convolution reference model.
module tb_pe_conv_engine;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned IMG_SIZE  = 11;
  localparam int unsigned K         = 3;
  localparam int unsigned STRIDE    = 2;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 24;
  localparam int unsigned SHIFT     = 2;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned MEM_DEPTH = 8;

  localparam int unsigned NPIX     = IMG_SIZE * IMG_SIZE;
  localparam int unsigned OD       = (IMG_SIZE - K) / STRIDE + 1;
  localparam int unsigned NOUT     = OD * OD;
  localparam int unsigned NWORD    = (NOUT + 3) / 4;
  localparam int unsigned AW       = $clog2(NPIX);
  localparam int unsigned MAW      = $clog2(MEM_DEPTH);
  localparam int unsigned DONE_CYC = NOUT * (K * K + 2) + 1;

  logic                         clk;
  logic                         rst;
  logic                         start;
  logic                         sat_en;
  logic                         busy;
  logic                         done;
  logic                         img_rd_en;
  logic [AW-1:0]                img_rd_addr;
  logic [NUM_CH*DATA_W-1:0]     img_rd_data;
  logic [NUM_CH*K*K*DATA_W-1:0] filt_w;
  logic [MAW-1:0]               res_rd_addr;
  logic [4*OUT_W-1:0]           res_rd_data;
  logic [MAW:0]                 wr_count;

  pe_conv_engine #(
    .NUM_CH(NUM_CH), .IMG_SIZE(IMG_SIZE), .K(K), .STRIDE(STRIDE), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sat_en(sat_en), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .filt_w(filt_w), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned pix [NUM_CH][NPIX];
  int unsigned wt  [NUM_CH][K*K];
  int unsigned exp_word [NWORD];
  int unsigned exp_addr [$];
  int unsigned addr_err;
  int unsigned addr_seen;
  int unsigned n_vec;
  int unsigned n_err;

  // Image memory: one-cycle read latency, plus an in-order check of the requested addresses.
  always @(posedge clk) begin
    if (img_rd_en) begin
      if (exp_addr.size() == 0) begin
        addr_err++;
      end else begin
        if (exp_addr[0] != 32'(img_rd_addr)) addr_err++;
        void'(exp_addr.pop_front());
      end
      addr_seen++;
      for (int c = 0; c < NUM_CH; c++) begin
        img_rd_data[c*DATA_W +: DATA_W] <= DATA_W'(pix[c][img_rd_addr]);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // mode 0: random values in a random range, 1: all ones, 2: all full-scale.
  task automatic build_model(input int mode, input bit sat);
    int unsigned maxv, sum, s, r, a, i, omax;
    case ($urandom_range(0, 3))
      0:       maxv = 1;
      1:       maxv = 15;
      2:       maxv = 63;
      default: maxv = 255;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < NPIX; p++)
        pix[c][p] = (mode == 1) ? 1 : (mode == 2) ? 255 : $urandom_range(0, maxv);
      for (int t = 0; t < K*K; t++) begin
        wt[c][t] = (mode == 1) ? 1 : (mode == 2) ? 255 : $urandom_range(0, maxv);
        filt_w[(c*K*K + t)*DATA_W +: DATA_W] = DATA_W'(wt[c][t]);
      end
    end
    omax = (1 << OUT_W) - 1;
    exp_addr.delete();
    for (int w = 0; w < NWORD; w++) exp_word[w] = 0;
    for (int oy = 0; oy < OD; oy++) begin
      for (int ox = 0; ox < OD; ox++) begin
        sum = 0;
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) begin
            a = (oy*STRIDE + ky) * IMG_SIZE + ox*STRIDE + kx;
            exp_addr.push_back(a);
            for (int c = 0; c < NUM_CH; c++) sum += pix[c][a] * wt[c][ky*K + kx];
          end
        end
        s = sum >> SHIFT;
        r = sat ? ((s > omax) ? omax : s) : (s & omax);
        i = oy * OD + ox;
        exp_word[i/4] |= r << (OUT_W * (i % 4));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy),        0);
    check_eq({tag, "_done"},  32'(done),        0);
    check_eq({tag, "_rden"},  32'(img_rd_en),   0);
    check_eq({tag, "_rdadr"}, 32'(img_rd_addr), 0);
    check_eq({tag, "_wrcnt"}, 32'(wr_count),    0);
    check_eq({tag, "_rdat"},  32'(res_rd_data), 0);
  endtask

  task automatic run(input int mode, input bit sat, input bit pulses, input int abort_at);
    int unsigned done_cyc, done_cnt;
    bit          busy_ok;
    logic [31:0] rd0;
    build_model(mode, sat);
    addr_err    = 0;
    addr_seen   = 0;
    res_rd_addr = '0;
    @(negedge clk);
    sat_en = sat;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    sat_en = ~sat;
    check_eq("busy_rise", 32'(busy), 1);
    done_cyc = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    rd0      = '0;
    for (int cyc = 1; cyc <= int'(DONE_CYC) + 6; cyc++) begin
      if (abort_at != 0 && cyc == abort_at) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        exp_addr.delete();
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        if (busy) busy_ok = 1'b0;
        rd0 = res_rd_data;
      end else if (cyc < int'(DONE_CYC) && !busy) begin
        busy_ok = 1'b0;
      end
      start = pulses && ((cyc % 7 == 0 && cyc < int'(DONE_CYC)) || done);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_cycle",  done_cyc,    DONE_CYC);
    check_eq("done_pulses", done_cnt,    1);
    check_eq("busy_window", 32'(busy_ok), 1);
    check_eq("addr_errors", addr_err,    0);
    check_eq("addr_count",  addr_seen,   NOUT * K * K);
    check_eq("wr_count",    32'(wr_count), NWORD);
    check_eq("rd0_in_run",  rd0,         exp_word[0]);
    for (int w = 0; w < NWORD; w++) begin
      res_rd_addr = MAW'(w);
      @(negedge clk);
      check_eq($sformatf("word%0d", w), res_rd_data, exp_word[w]);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b0;
    start       = 1'b0;
    sat_en      = 1'b0;
    res_rd_addr = '0;
    filt_w      = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);
    run(1, 1'b1, 1'b0, 0);
    run(2, 1'b1, 1'b0, 0);
    run(2, 1'b0, 1'b0, 0);
    run(0, 1'b1, 1'b0, 100);
    run(1, 1'b1, 1'b0, 0);
    run(0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      run(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
